// File: rtl/semaforo_pkg.sv
// semaforo_pkg: shared state encoding and lamp codes for the traffic-light controller
package semaforo_pkg;
  typedef enum logic [2:0] {VERDE, AMARELO, VERMELHO, PEDESTRE, PISCA} estado_t;
  localparam logic [2:0] LUZ_VERDE    = 3'b001;
  localparam logic [2:0] LUZ_AMARELO  = 3'b010;
  localparam logic [2:0] LUZ_VERMELHO = 3'b100;
  localparam logic [2:0] LUZ_APAGADA  = 3'b000;
endpackage

// File: rtl/semaforo_multi_contador_fase.sv
// contador_fase: down-counter with synchronous load and zero flag timing each phase
module contador_fase #(
  parameter int CW = 8,
  parameter logic [CW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] val,
  output logic          zero
);
  logic [CW-1:0] cnt;
  // reload on phase entry or expiry, otherwise count down
  always_ff @(posedge clk)
    if (rst) cnt <= RST_VAL;
    else cnt <= load ? val : cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/semaforo_multi.sv
// semaforo_multi: round-robin N-approach traffic light with pedestrian walk and night flash
module semaforo_multi import semaforo_pkg::*; #(
  parameter int N          = 2,
  parameter int CW         = 8,
  parameter int T_VERDE    = 4,
  parameter int T_AMARELO  = 3,
  parameter int T_VERMELHO = 2,
  parameter int T_PED      = 5,
  parameter int T_PISCA    = 2,
  localparam int IW        = N > 1 ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bt,
  input  logic            noite,
  output logic [3*N-1:0]  luz,
  output logic            walk,
  output logic [IW-1:0]   idx
);
  estado_t state, nxt;
  logic zero, ped_pend, fase;
  function automatic logic [CW-1:0] dur(estado_t s);
    return CW'(s == VERDE ? T_VERDE : s == AMARELO ? T_AMARELO : s == VERMELHO ? T_VERMELHO :
               s == PEDESTRE ? T_PED : T_PISCA) - 1'b1;
  endfunction
  // the flash phase reloads its own half-period, so expiry alone also reloads
  contador_fase #(.CW(CW), .RST_VAL(CW'(T_VERDE - 1))) u_cnt (
    .clk(clk), .rst(rst), .load(zero || nxt != state), .val(dur(nxt)), .zero(zero)
  );
  // state register
  always_ff @(posedge clk)
    if (rst) state <= VERDE;
    else state <= nxt;
  // next-state logic: night mode cuts green short, walk phase always completes
  always_comb begin
    nxt = state;
    case (state)
      VERDE:    nxt = noite || zero ? AMARELO : VERDE;
      AMARELO:  nxt = zero ? VERMELHO : AMARELO;
      VERMELHO: nxt = !zero ? VERMELHO : noite ? PISCA : ped_pend ? PEDESTRE : VERDE;
      PEDESTRE: nxt = zero ? VERDE : PEDESTRE;
      PISCA:    nxt = noite ? PISCA : VERMELHO;
      default:  nxt = VERDE;
    endcase
  end
  // approach index, latched pedestrian request and flash phase
  always_ff @(posedge clk)
    if (rst) begin
      idx      <= '0;
      ped_pend <= 1'b0;
      fase     <= 1'b1;
    end else begin
      if (nxt == VERDE && state != VERDE) idx <= idx == IW'(N - 1) ? '0 : idx + 1'b1;
      else if (state == PISCA && nxt == VERMELHO) idx <= IW'(N - 1);
      ped_pend <= !(nxt inside {PEDESTRE, PISCA}) &&
                  (ped_pend || (bt && !(state inside {PEDESTRE, PISCA})));
      fase     <= state == PISCA && nxt == PISCA ? fase ^ zero : 1'b1;
    end
  // Moore output decode
  always_comb walk = state == PEDESTRE;
  for (genvar i = 0; i < N; i++) begin : g_luz
    assign luz[3*i +: 3] = state == PISCA ? (fase ? LUZ_AMARELO : LUZ_APAGADA) :
                           IW'(i) == idx && state == VERDE   ? LUZ_VERDE   :
                           IW'(i) == idx && state == AMARELO ? LUZ_AMARELO : LUZ_VERMELHO;
  end
endmodule

// File: tb/tb_semaforo_multi.sv
// tb_semaforo_multi: scenario and randomized checks against a phase-timing reference model
module tb_semaforo_multi;
  localparam int N = 2, TV = 4, TA = 3, TR = 2, TP = 5, TF = 2;
  logic clk = 0, rst = 1, bt = 0, noite = 0, rst3 = 1;
  logic [3*N-1:0] luz;
  logic walk;
  logic [0:0] idx;
  logic [8:0] luz3;
  logic walk3;
  logic [1:0] idx3;
  int checks = 0, errors = 0;
  int m_ph, m_el, m_idx;
  bit m_pend, m_on;

  semaforo_multi dut (.clk(clk), .rst(rst), .bt(bt), .noite(noite), .luz(luz), .walk(walk), .idx(idx));
  semaforo_multi #(.N(3), .T_VERDE(255)) dut3 (.clk(clk), .rst(rst3), .bt(1'b0), .noite(1'b0),
                                               .luz(luz3), .walk(walk3), .idx(idx3));

  always #5 clk = ~clk;

  // phases: 0 green, 1 yellow, 2 all-red, 3 walk, 4 flash
  function automatic int plen(int ph);
    return ph == 0 ? TV : ph == 1 ? TA : ph == 2 ? TR : ph == 3 ? TP : TF;
  endfunction

  function automatic logic [3*N-1:0] exp_luz();
    logic [3*N-1:0] r;
    for (int i = 0; i < N; i++)
      r[3*i +: 3] = m_ph == 4 ? (m_on ? 3'b010 : 3'b000) :
                    (i == m_idx && m_ph == 0) ? 3'b001 :
                    (i == m_idx && m_ph == 1) ? 3'b010 : 3'b100;
    return r;
  endfunction

  task automatic model_edge();
    int nx;
    bit last, set;
    if (rst) begin
      m_ph = 0; m_el = 0; m_idx = 0; m_pend = 0; m_on = 1;
    end else begin
      last = m_el == plen(m_ph) - 1;
      set = bt && m_ph != 3 && m_ph != 4;
      nx = m_ph;
      case (m_ph)
        0: if (noite || last) nx = 1;
        1: if (last) nx = 2;
        2: if (last) nx = noite ? 4 : (m_pend ? 3 : 0);
        3: if (last) nx = 0;
        default: if (!noite) nx = 2;
      endcase
      if (nx == 0 && m_ph != 0) m_idx = (m_idx + 1) % N;
      if (m_ph == 4 && nx == 2) m_idx = N - 1;
      if (nx != m_ph) begin
        m_el = 0; m_on = 1;
        m_pend = (nx == 3 || nx == 4) ? 0 : (m_pend | set);
      end else if (m_ph == 4 && last) begin
        m_el = 0; m_on = !m_on;
      end else begin
        m_el++; m_pend |= set;
      end
      m_ph = nx;
    end
  endtask

  task automatic step(input bit b, input bit n, input bit r);
    bt = b; noite = n; rst = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 1);
    checks++;
    if (luz !== 6'b100001 || walk !== 1'b0 || idx !== 1'b0) begin
      errors++;
      $display("FAIL reset luz=%b walk=%b idx=%0d required luz=100001 walk=0 idx=0", luz, walk, idx);
    end
  endtask

  task automatic test_basic_cycle();
    for (int c = 1; c <= 19; c++) begin
      checks++;
      if (luz !== exp_luz() || walk !== (m_ph == 3) || idx !== 1'(m_idx)) begin
        errors++;
        $display("FAIL basic c=%0d luz=%b walk=%b idx=%0d required %b %b %0d", c, luz, walk, idx, exp_luz(), m_ph == 3, m_idx);
      end
      checks++;
      if ((c <= 4 && luz[2:0] !== 3'b001) || (c >= 5 && c <= 7 && luz[2:0] !== 3'b010) ||
          (c >= 8 && c <= 9 && luz !== 6'b100100) || (c == 10 && (luz[5:3] !== 3'b001 || idx !== 1'b1)) ||
          (c == 19 && (luz[2:0] !== 3'b001 || idx !== 1'b0))) begin
        errors++;
        $display("FAIL basic_timeline c=%0d luz=%b idx=%0d", c, luz, idx);
      end
      step(0, 0, 0);
    end
  endtask

  task automatic test_pedestrian();
    step(0, 0, 1);
    for (int c = 1; c <= 40; c++) begin
      checks++;
      if (luz !== exp_luz() || walk !== (m_ph == 3) || idx !== 1'(m_idx)) begin
        errors++;
        $display("FAIL ped c=%0d luz=%b walk=%b idx=%0d required %b %b %0d", c, luz, walk, idx, exp_luz(), m_ph == 3, m_idx);
      end
      checks++;
      if (walk !== (c >= 10 && c <= 14) || (walk && luz !== 6'b100100) || (c == 15 && luz[5:3] !== 3'b001)) begin
        errors++;
        $display("FAIL ped_timeline c=%0d walk=%b luz=%b required walk=%b", c, walk, luz, c >= 10 && c <= 14);
      end
      step(c == 2 || c == 11, 0, 0);
    end
  endtask

  task automatic test_night();
    logic [5:0] e;
    step(0, 0, 1);
    for (int c = 1; c <= 50; c++) begin
      checks++;
      if (luz !== exp_luz() || walk !== (m_ph == 3) || idx !== 1'(m_idx)) begin
        errors++;
        $display("FAIL night c=%0d luz=%b walk=%b idx=%0d required %b %b %0d", c, luz, walk, idx, exp_luz(), m_ph == 3, m_idx);
      end
      e = c == 3 ? 6'b100010 : (c >= 8 && c <= 40) ? ((((c - 8) / 2) % 2 == 0) ? 6'b010010 : 6'b000000) :
          (c == 41 || c == 42) ? 6'b100100 : c == 43 ? 6'b100001 : luz;
      checks++;
      if (luz !== e) begin
        errors++;
        $display("FAIL night_timeline c=%0d luz=%b required %b", c, luz, e);
      end
      step(0, c >= 2 && c < 40, 0);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 1);
    for (int c = 1; c <= 50; c++) begin
      checks++;
      if (luz !== exp_luz() || walk !== (m_ph == 3) || idx !== 1'(m_idx)) begin
        errors++;
        $display("FAIL rstmid c=%0d luz=%b walk=%b idx=%0d required %b %b %0d", c, luz, walk, idx, exp_luz(), m_ph == 3, m_idx);
      end
      checks++;
      if ((c == 15 && luz !== 6'b010100) || (c == 16 && (luz !== 6'b100001 || idx !== 1'b0)) || (c >= 16 && walk !== 1'b0)) begin
        errors++;
        $display("FAIL rstmid_timeline c=%0d luz=%b walk=%b idx=%0d", c, luz, walk, idx);
      end
      step(c == 11, 0, c == 15);
    end
  endtask

  task automatic test_random();
    bit nt = 0;
    step(0, 0, 1);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) nt = !nt;
      step($urandom_range(5) == 0, nt, $urandom_range(399) == 0);
      checks++;
      if (luz !== exp_luz() || walk !== (m_ph == 3) || idx !== 1'(m_idx)) begin
        errors++;
        $display("FAIL random c=%0d luz=%b walk=%b idx=%0d required %b %b %0d", c, luz, walk, idx, exp_luz(), m_ph == 3, m_idx);
      end
    end
  endtask

  task automatic test_wrap();
    int seen = 0, run = 0;
    int seq[4];
    rst3 = 1;
    @(posedge clk);
    #1;
    rst3 = 0;
    for (int c = 0; c < 1200 && seen < 4; c++) begin
      if (idx3 > 2) begin
        errors++;
        $display("FAIL wrap_range idx3=%0d required <=2", idx3);
      end
      if (luz3[3*idx3 +: 3] === 3'b001) begin
        if (run == 0) begin seq[seen] = idx3; seen++; end
        run++;
      end else if (run > 0) begin
        checks++;
        if (run != 255) begin
          errors++;
          $display("FAIL wrap_green_len len=%0d required 255", run);
        end
        run = 0;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen != 4 || seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 0) begin
      errors++;
      $display("FAIL wrap_seq seen=%0d seq=%0d,%0d,%0d,%0d required 4 0,1,2,0", seen, seq[0], seq[1], seq[2], seq[3]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_cycle();
    test_pedestrian();
    test_night();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
